fifo_enq_arbiter: RTL
=====================

FIFO_ENQ_ARBITER -- requirements
Module: fifo_enq_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data width of every stream.
REQ-002 Parameter: NREQ, 4, number of requesters; power of two, >= 2.
REQ-003 Parameter: BURST, 4, max beats per grant; >= 1.
REQ-004 Localparam: LOGNREQ = log2(NREQ), used for requester index width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  NREQ  per-requester valid; bit i belongs to requester i.
REQ-008 in_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  NREQ  per-requester ready.
REQ-010 out_valid  output  1  to the FIFO enq_valid.
REQ-011 out_data  output  WIDTH  to the FIFO enq_data.
REQ-012 out_ready  input  1  from the FIFO enq_ready.
REQ-013 grant_valid  output  1  high while a requester holds the grant.
REQ-014 grant_id  output  LOGNREQ  index of the current grant holder.

Function
REQ-015 Two states, IDLE and GRANT; state, grant_id, last_winner and beat count are registers.
REQ-016 IDLE: out_valid=0, all in_ready=0, grant_valid=0.
REQ-017 IDLE with any in_valid high: winner = first requester with valid high, searching from (last_winner+1) mod NREQ upward with wrap-around; register grant_id=winner, clear beat count, go to GRANT next cycle.
REQ-018 IDLE with no in_valid high: stay IDLE; last_winner unchanged.
REQ-019 Arbitration latency is exactly one cycle, from IDLE sampling in_valid to GRANT; no data moves in the IDLE cycle.
REQ-020 GRANT: out_valid=in_valid[grant_id]; out_data=in_data[grant_id]; in_ready[grant_id]=out_ready; all other in_ready bits 0; grant_valid=1.
REQ-021 Fire = out_valid && out_ready; each fire increments the beat count by 1.
REQ-022 Release on a fire with beat count == BURST-1, or in any GRANT cycle with in_valid[grant_id]==0.
REQ-023 On release: last_winner <= grant_id; state <= IDLE; beat count <= 0.
REQ-024 out_ready low in GRANT: hold the grant indefinitely; beat count unchanged; no timeout.
REQ-025 The arbiter never drops, duplicates or reorders beats within a requester's stream.
REQ-026 Beat count width is sufficient for BURST-1. With BURST=1 every fire releases.
REQ-027 in_valid on non-granted requesters is ignored until the next IDLE arbitration; they see in_ready=0.
REQ-028 Fairness: a continuously requesting requester is granted within NREQ-1 other grants.

Reset
REQ-029 rst high at a clock edge: state=IDLE, grant_id=0, last_winner=NREQ-1, beat count=0.
REQ-030 After reset: out_valid=0, in_ready=0, grant_valid=0. The first arbitration favours requester 0.
REQ-031 Reset mid-burst aborts the grant; beats already fired stay in the FIFO; no partial-beat state is retained.

Verification
REQ-032 After reset, all 4 in_valid held high, out_ready=1, BURST=4: grants go 0,1,2,3,0. Each grant is 4 consecutive fires with one IDLE cycle between grants. out_data matches each requester's sequence.
REQ-033 Only requester 2 valid, 10 beats queued: bursts of 4, 4 and 2 beats to requester 2, each preceded by one IDLE cycle. The grant releases when requester 2 valid drops after beat 10.
REQ-034 Requester 1 granted, drops valid after 2 fires while 2 and 3 are valid: the grant releases; after one IDLE cycle requester 2 is granted.
REQ-035 out_ready=0 for 5 cycles mid-burst after beat 1: grant_id stable and in_ready[grant_id]=0 throughout. Beats 2-4 follow when ready returns, with no loss or duplication.
REQ-036 rst asserted during requester 3's second beat: next cycle grant_valid=0 and in_ready=0. With all requesters valid after reset, requester 0 wins.
REQ-037 Connected to the 8-entry, 32-bit FIFO with dequeue stalled: exactly 8 fires, then out_ready low and the arbiter holds. Resuming dequeue drains the beats in exact enqueue order.

Source files
------------

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter that grants one of NREQ valid/ready streams at a time
// and forwards up to BURST beats per grant into a FIFO enqueue port.
module fifo_enq_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_in_valid,
  input  logic [NREQ*WIDTH-1:0] i_in_data,
  output logic [NREQ-1:0]       o_in_ready,
  output logic                  o_out_valid,
  output logic [WIDTH-1:0]      o_out_data,
  input  logic                  i_out_ready,
  output logic                  o_grant_valid,
  output logic [$clog2(NREQ)-1:0] o_grant_id
);

  localparam int LOGNREQ = $clog2(NREQ);
  localparam int BCW     = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]         r_state;
  logic [LOGNREQ-1:0] r_grant_id;
  logic [LOGNREQ-1:0] r_last_winner;
  logic [BCW-1:0]     r_beat_cnt;

  logic [WIDTH-1:0]   w_data_arr [NREQ];
  logic               w_grant;
  logic               w_sel_valid;
  logic               w_fire;
  logic               w_release;
  logic               w_found;
  logic [LOGNREQ-1:0] w_winner;
  logic [LOGNREQ-1:0] w_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_data_arr[g] = i_in_data[g*WIDTH +: WIDTH];
  end

  assign w_grant     = (r_state == ST_GRANT);
  assign w_sel_valid = i_in_valid[r_grant_id];
  assign w_fire      = o_out_valid && i_out_ready;
  // A grant ends on its last beat or as soon as the holder stops offering data.
  assign w_release   = w_grant &&
                       (!w_sel_valid || (w_fire && (r_beat_cnt == BCW'(BURST-1))));

  // Round-robin search starting just after the previous winner; k == NREQ wraps to last_winner itself.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_winner;
    w_idx    = r_last_winner;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = r_last_winner + LOGNREQ'(k);
      if (!w_found && i_in_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Output steering toward the granted requester.
  always_comb begin
    o_in_ready    = {NREQ{1'b0}};
    o_grant_valid = w_grant;
    o_grant_id    = r_grant_id;
    if (w_grant) begin
      o_out_valid = w_sel_valid;
      o_out_data  = w_data_arr[r_grant_id];
      for (int i = 0; i < NREQ; i++) begin
        o_in_ready[i] = (r_grant_id == LOGNREQ'(i)) && i_out_ready;
      end
    end else begin
      o_out_valid = 1'b0;
      o_out_data  = {WIDTH{1'b0}};
    end
  end

  // State, grant holder, round-robin pointer and beat counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_grant_id    <= {LOGNREQ{1'b0}};
      r_last_winner <= LOGNREQ'(NREQ-1);
      r_beat_cnt    <= {BCW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_winner;
            r_beat_cnt <= {BCW{1'b0}};
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_last_winner <= r_grant_id;
            r_beat_cnt    <= {BCW{1'b0}};
            r_state       <= ST_IDLE;
          end else if (w_fire) begin
            r_beat_cnt <= r_beat_cnt + BCW'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_beat_cnt <= {BCW{1'b0}};
        end
      endcase
    end
  end

endmodule
